// File: rtl/egg_timer_datapath.sv
// Egg-timer countdown datapath: captures MM:SS from switches, counts down once per second in TIMER.
// Latency: every output is registered and reacts one clk after the state/set_val change that causes it.
// Backpressure: none (free-running); optional macro TIMER_PAUSE_EN lets `pause` freeze the countdown in TIMER.
module egg_timer_datapath #(
  parameter int CLK_HZ  = 50000000,
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [7:0] set_val,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       done,
  output logic       half_tick,
  output logic       blank
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);
  localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  localparam logic [2:0] ST_SET_SEC     = 3'd0;
  localparam logic [2:0] ST_SET_MIN     = 3'd1;
  localparam logic [2:0] ST_TIMER       = 3'd2;
  localparam logic [2:0] ST_READY       = 3'd3;
  localparam logic [2:0] ST_RESET       = 3'd4;
  localparam logic [2:0] ST_FLASH_ON    = 3'd5;
  localparam logic [2:0] ST_FLASH_OFF   = 3'd6;
  localparam logic [2:0] ST_SETTING_MIN = 3'd7;

  logic [7:0]    r_min;
  logic [7:0]    r_sec;
  logic [PW-1:0] r_presc;
  logic          r_phase;
  logic          r_done;
  logic          r_half;
  logic          r_blank;

  logic          w_pause;
  logic [3:0]    w_units;
  logic [3:0]    w_sec_tens;
  logic [7:0]    w_sec_set;
  logic [7:0]    w_min_num;
  logic [7:0]    w_min_set;
  logic [7:0]    w_sec_next;
  logic [7:0]    w_min_next;
  logic          w_wrap;
  logic          w_active;

`ifdef TIMER_PAUSE_EN
  assign w_pause = pause;
`else
  // pause is deliberately masked off when the feature is compiled out
  assign w_pause = pause & 1'b0;
`endif

  // Switch sanitising: units clamp to 9, seconds tens to 5, minutes value to MAX_MIN.
  assign w_units    = (set_val[3:0] > 4'd9) ? 4'd9 : set_val[3:0];
  assign w_sec_tens = (set_val[7:4] > 4'd5) ? 4'd5 : set_val[7:4];
  assign w_sec_set  = {w_sec_tens, w_units};
  assign w_min_num  = ({4'b0, set_val[7:4]} * 8'd10) + {4'b0, w_units};
  assign w_min_set  = (w_min_num > 8'(MAX_MIN)) ? MAX_BCD : {set_val[7:4], w_units};

  assign w_wrap   = (r_presc == HALF_LAST);
  assign w_active = (state == ST_FLASH_ON) || (state == ST_FLASH_OFF) ||
                    ((state == ST_TIMER) && !w_pause);

  // BCD decrement of MM:SS by one second, saturating at 00:00.
  always_comb begin
    w_sec_next = r_sec;
    w_min_next = r_min;
    if (r_sec[3:0] != 4'd0) begin
      w_sec_next[3:0] = r_sec[3:0] - 4'd1;
    end else if (r_sec[7:4] != 4'd0) begin
      w_sec_next = {r_sec[7:4] - 4'd1, 4'd9};
    end else if (r_min != 8'h00) begin
      w_sec_next = 8'h59;
      if (r_min[3:0] != 4'd0) begin
        w_min_next[3:0] = r_min[3:0] - 4'd1;
      end else begin
        w_min_next = {r_min[7:4] - 4'd1, 4'd9};
      end
    end
  end

  // Per-state capture, prescaler/phase pacing and countdown; flags track the state seen this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
      r_presc <= '0;
      r_phase <= 1'b0;
      r_done  <= 1'b0;
      r_half  <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_done  <= ((state == ST_TIMER) || (state == ST_FLASH_ON) || (state == ST_FLASH_OFF)) &&
                 (r_min == 8'h00) && (r_sec == 8'h00);
      r_blank <= (state == ST_FLASH_OFF);
      r_half  <= 1'b0;
      case (state)
        ST_RESET: begin
          r_min   <= 8'h00;
          r_sec   <= 8'h00;
          r_presc <= '0;
          r_phase <= 1'b0;
        end
        ST_SET_SEC: begin
          r_sec   <= w_sec_set;
          r_presc <= '0;
          r_phase <= 1'b0;
        end
        ST_SET_MIN, ST_SETTING_MIN: begin
          r_min   <= w_min_set;
          r_presc <= '0;
          r_phase <= 1'b0;
        end
        ST_READY: begin
          // cleared here so the first TIMER second is a full one
          r_presc <= '0;
          r_phase <= 1'b0;
        end
        ST_TIMER, ST_FLASH_ON, ST_FLASH_OFF: begin
          if (w_active) begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
              r_half  <= 1'b1;
              r_phase <= ~r_phase;
              // second boundary is the phase 1->0 wrap; only TIMER consumes it
              if (r_phase && (state == ST_TIMER)) begin
                r_min <= w_min_next;
                r_sec <= w_sec_next;
              end
            end
          end
        end
        default: begin
          r_presc <= '0;
        end
      endcase
    end
  end

  assign min_bcd   = r_min;
  assign sec_bcd   = r_sec;
  assign done      = r_done;
  assign half_tick = r_half;
  assign blank     = r_blank;

endmodule

// File: tb/tb_egg_timer_datapath.sv
// Bench for egg_timer_datapath at CLK_HZ=4: directed scenarios plus randomized state/switch traffic.
// Latency: a decimal-arithmetic model updated each rising edge is compared on every falling edge.
// Backpressure: none; pause is honoured by the model only when TIMER_PAUSE_EN is defined.
module tb_egg_timer_datapath;

  localparam int CLK_HZ = 4;
  localparam int HALF   = CLK_HZ / 2;

  localparam logic [2:0] S_SET_SEC  = 3'd0;
  localparam logic [2:0] S_SET_MIN  = 3'd1;
  localparam logic [2:0] S_TIMER    = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_RESET    = 3'd4;
  localparam logic [2:0] S_FLASH_ON = 3'd5;
  localparam logic [2:0] S_FLASH_OFF= 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'd4;
  logic [7:0] set_val = 8'h00;
  logic       pause = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       done;
  logic       half_tick;
  logic       blank;

  int errors = 0;
  int checks = 0;

  // reference model state: decimal minutes/seconds and cycles run since pacing was cleared
  int   m_min = 0;
  int   m_sec = 0;
  int   m_run = 0;
  logic e_done = 1'b0;
  logic e_ht = 1'b0;
  logic e_blank = 1'b0;

  egg_timer_datapath #(.CLK_HZ(CLK_HZ), .MAX_MIN(99)) dut (
    .clk(clk), .rst(rst), .state(state), .set_val(set_val), .pause(pause),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .done(done), .half_tick(half_tick), .blank(blank)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic logic [7:0] to_bcd(int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic pz;
    int   su, st, mu, mt;
    if (rst) begin
      m_min = 0; m_sec = 0; m_run = 0;
      e_done = 1'b0; e_ht = 1'b0; e_blank = 1'b0;
    end else begin
`ifdef TIMER_PAUSE_EN
      pz = pause;
`else
      pz = 1'b0;
`endif
      e_done  = (state == S_TIMER || state == S_FLASH_ON || state == S_FLASH_OFF) &&
                m_min == 0 && m_sec == 0;
      e_blank = (state == S_FLASH_OFF);
      e_ht    = 1'b0;
      su = clampi(int'(set_val[3:0]), 9);
      st = clampi(int'(set_val[7:4]), 5);
      mt = int'(set_val[7:4]);
      mu = su;
      case (state)
        S_RESET: begin m_min = 0; m_sec = 0; m_run = 0; end
        S_SET_SEC: begin m_sec = st * 10 + su; m_run = 0; end
        3'd1, 3'd7: begin m_min = clampi(mt * 10 + mu, 99); m_run = 0; end
        S_READY: m_run = 0;
        default: begin
          if (!(state == S_TIMER && pz)) begin
            m_run++;
            e_ht = (m_run % HALF) == 0;
            if (state == S_TIMER && (m_run % (2 * HALF)) == 0) begin
              if (m_sec > 0) m_sec--;
              else if (m_min > 0) begin m_min--; m_sec = 59; end
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // continuous comparison against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_min", min_bcd, to_bcd(m_min));
      chk("m_sec", sec_bcd, to_bcd(m_sec));
      chk("m_done", {7'b0, done}, {7'b0, e_done});
      chk("m_half", {7'b0, half_tick}, {7'b0, e_ht});
      chk("m_blank", {7'b0, blank}, {7'b0, e_blank});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] s, input logic [7:0] v);
    state = s;
    set_val = v;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    drive(S_RESET, 8'h00);
    cyc(1);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_flags", {5'b0, done, half_tick, blank}, 8'h00);

    // seconds capture with both digit clamps
    drive(S_SET_SEC, 8'h7C); cyc(1);
    chk("clamp_sec", sec_bcd, 8'h59);

    // 01:02 countdown
    drive(S_SET_MIN, 8'h01); cyc(1);
    chk("set_min", min_bcd, 8'h01);
    drive(S_SET_SEC, 8'h02); cyc(1);
    drive(S_READY, 8'h00);   cyc(1);
    drive(S_TIMER, 8'h00);   cyc(2);
    chk("ht_first", {7'b0, half_tick}, 8'h01);
    chk("hold_0102", sec_bcd, 8'h02);
    cyc(1);
    chk("ht_gap", {7'b0, half_tick}, 8'h00);
    cyc(1);
    chk("t_0101", {min_bcd, sec_bcd} == 16'h0101 ? 8'h01 : 8'h00, 8'h01);
    cyc(4);
    chk("t_0100", {min_bcd, sec_bcd} == 16'h0100 ? 8'h01 : 8'h00, 8'h01);
    cyc(4);
    chk("t_0059_min", min_bcd, 8'h00);
    chk("t_0059_sec", sec_bcd, 8'h59);
    chk("t_0059_done", {7'b0, done}, 8'h00);

    // 00:02 to saturation
    drive(S_SET_MIN, 8'h00); cyc(1);
    drive(S_SET_SEC, 8'h02); cyc(1);
    drive(S_READY, 8'h00);   cyc(1);
    drive(S_TIMER, 8'h00);   cyc(4);
    chk("z_0001", sec_bcd, 8'h01);
    cyc(4);
    chk("z_0000", sec_bcd, 8'h00);
    chk("z_done_lag", {7'b0, done}, 8'h00);
    cyc(1);
    chk("z_done", {7'b0, done}, 8'h01);
    cyc(8);
    chk("z_sat", {min_bcd, sec_bcd} == 16'h0000 ? 8'h01 : 8'h00, 8'h01);

    // flash alternation at 00:00
    for (int i = 0; i < 3; i++) begin
      drive(S_FLASH_OFF, 8'h00); cyc(1);
      chk("fl_blank_on", {7'b0, blank}, 8'h01);
      chk("fl_done", {7'b0, done}, 8'h01);
      drive(S_FLASH_ON, 8'h00); cyc(1);
      chk("fl_blank_off", {7'b0, blank}, 8'h00);
    end

    // asynchronous reset mid-count
    drive(S_SET_SEC, 8'h30); cyc(1);
    drive(S_READY, 8'h00);   cyc(1);
    drive(S_TIMER, 8'h00);   cyc(5);
    rst = 1'b1;
    #1;
    chk("arst_min", min_bcd, 8'h00);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_flags", {5'b0, done, half_tick, blank}, 8'h00);
    cyc(1);
    rst = 1'b0;
    drive(S_RESET, 8'h00); cyc(1);
    drive(S_SET_SEC, 8'h45); cyc(1);
    chk("recap_sec", sec_bcd, 8'h45);

    // randomized traffic checked by the model
    for (int i = 0; i < 70; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: state = S_TIMER;
        4: state = S_FLASH_ON;
        5: state = S_FLASH_OFF;
        6: state = S_SET_SEC;
        7: state = ($urandom_range(0, 1) == 0) ? S_SET_MIN : 3'd7;
        8: state = S_READY;
        default: state = 3'($urandom_range(0, 7));
      endcase
      set_val = 8'($urandom);
      pause = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 12));
    end
    pause = 1'b0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/egg_timer_datapath.md
Name: egg_timer_datapath

Overview:
- Countdown datapath directly downstream of the egg-timer controller FSM; consumes its 3-bit `state` code.
- Captures the minutes/seconds entered on the switches and counts down once per second in TIMER.
- Produces the `done` flag the controller needs to leave TIMER, plus a half-second tick for flash pacing and display-blank control.
- Outputs drive the 7-segment decoders.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; half-second period = CLK_HZ/2 cycles (CLK_HZ even, >= 4).
- MAX_MIN, 99, upper clamp for the minutes value (BCD-valid, <= 99).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- state  input  3  controller state code: RESET=4, SET_SEC=0, SET_MIN=1, SETTING_MIN=7, READY=3, TIMER=2, FLASH_ON=5, FLASH_OFF=6.
- set_val  input  8  two BCD digits from switches: [7:4] tens, [3:0] units.
- pause  input  1  freeze countdown; used only with TIMER_PAUSE_EN, ignored otherwise.
- min_bcd  output  8  minutes, BCD.
- sec_bcd  output  8  seconds, BCD.
- done  output  1  level: countdown at 00:00 while in TIMER or flash states.
- half_tick  output  1  one-cycle pulse every CLK_HZ/2 cycles while the prescaler runs.
- blank  output  1  display blank request; high in FLASH_OFF.

Behaviour:
- Reset values (rst high): min_bcd=8'h00, sec_bcd=8'h00, done=0, half_tick=0, blank=0, prescaler=0, phase bit=0.
- All outputs are registered; each responds one clk after the `state` or `set_val` change that causes it.
- Input sanitising, applied on capture:
  - Any units digit > 9 is taken as 9.
  - Seconds tens digit > 5 is taken as 5.
  - Minutes value > MAX_MIN is taken as MAX_MIN.
- Per-state behaviour:
  - RESET: min=00, sec=00, prescaler and phase cleared, done=0.
  - SET_SEC: sec_bcd loads sanitised set_val every cycle; min_bcd held.
  - SET_MIN, SETTING_MIN: min_bcd loads sanitised set_val every cycle; sec_bcd held.
  - READY: both held; prescaler and phase cleared, so the first TIMER second is a full second.
  - TIMER:
    - Prescaler counts 0..CLK_HZ/2-1; on wrap, half_tick pulses and the phase bit toggles.
    - A second elapses on every wrap where phase goes 1 -> 0, i.e. every second half_tick.
  - FLASH_ON / FLASH_OFF: prescaler keeps running and half_tick keeps pulsing; the count is held.
  - Any undefined code: everything held, prescaler cleared.
- Decrement on each elapsed second in TIMER:
  - sec units > 0: units - 1.
  - Else sec tens > 0: tens - 1, units = 9.
  - Else if min != 00: sec = 59 and min decrements by BCD rules (units borrow from tens).
  - Else 00:00: no change, count saturates, never wraps to 99:59.
- done:
  - Registered; = 1 when (state in {TIMER, FLASH_ON, FLASH_OFF}) and min==00 and sec==00.
  - Entering TIMER already at 00:00 gives done=1 on the next cycle.
  - done drops to 0 one cycle after any other state is seen.
- blank = 1 exactly when state == FLASH_OFF (registered).
- Simultaneous events:
  - A state change on the same edge as a prescaler wrap uses the new state's rule; no stale decrement.
  - A decrement reaching 00:00 sets done on the following edge.
- Reset mid-operation: asynchronous clear of all registers regardless of the prescaler phase.
- The controller's RESET state has the same data effect as rst, but is synchronous.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Defined: in TIMER with pause=1, the prescaler, phase and count freeze; half_tick stays 0. Releasing pause resumes from the frozen prescaler value with no lost or extra second. pause has no effect in other states.
- Undefined: pause is ignored; the countdown is uninterrupted.

Test Plan:
- CLK_HZ=4 for all: rst pulse, then state=SET_SEC with set_val=8'h7C -> sec_bcd=8'h59 (tens clamped 7->5, units clamped C->9).
- SET_MIN set_val=8'h01, SET_SEC set_val=8'h02, READY, then TIMER -> 01:02, 01:01, 01:00, 00:59 at 4-cycle intervals; half_tick every 2 cycles; done=0.
- Load 00:02, run TIMER -> 00:01, then 00:00; done=1 the cycle after 00:00; further seconds keep 00:00 (no wrap).
- TIMER at 00:00 with state alternating FLASH_ON/FLASH_OFF -> blank follows FLASH_OFF with 1-cycle lag; done stays 1; half_tick continues.
- Mid-count 00:30, assert rst for one cycle between prescaler wraps -> all outputs 0 immediately; state=RESET then SET_SEC re-captures set_val.
- With TIMER_PAUSE_EN: pause=1 for 10 cycles during TIMER at 00:10 -> count, half_tick frozen; after release the next decrement lands on the remaining prescaler count.
